// File: rtl/board_win_scanner.sv
// board_win_scanner: walks every anchor of a Connect Four board snapshot, one per cycle, and keeps sticky
// red/black win, draw and bad-cell verdicts; define WIN_LOCATION_EN to latch the first winning anchor/direction.
module board_win_scanner #(
    parameter int ROWS    = 6,
    parameter int COLS    = 7,
    parameter int CONNECT = 4
) (
    input  logic                 frame_clk,
    input  logic                 Reset,
    input  logic                 start,
    input  logic                 clear_game,
    input  logic [ROWS*COLS-1:0] board_red,
    input  logic [ROWS*COLS-1:0] board_black,
    output logic                 busy,
    output logic                 done,
    output logic                 red_win,
    output logic                 black_win,
    output logic                 draw,
    output logic                 bad_cell,
    output logic [2:0]           win_row,
    output logic [2:0]           win_col,
    output logic [1:0]           win_dir
);
    localparam int N = ROWS * COLS;
    localparam logic [2:0] LAST_R = 3'(ROWS - 1);
    localparam logic [2:0] LAST_C = 3'(COLS - 1);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    state_t       state_q, state_d;
    logic [N-1:0] snap_r_q, snap_b_q, m_r, m_b;
    logic [2:0]   row_q, col_q;
    logic         pend_q, fr_q, fb_q, red_win_q, black_win_q, draw_q, bad_q;
    logic         last, load, fr_n, fb_n, full, bad_n;
    logic [3:0]   hit_r, hit_b;

    // True when CONNECT cells starting at (r,c) stepping (dr,dc) are all on the board and set in m
    function automatic logic run_at(input logic [N-1:0] m, input int r, input int c, input int dr, input int dc);
        logic         ok;
        logic [N-1:0] t;
        int           rr, cc;
        ok = 1'b1;
        for (int k = 0; k < CONNECT; k++) begin
            rr = r + k * dr;
            cc = c + k * dc;
            t  = m >> (rr * COLS + cc);
            ok = ok & (rr >= 0) & (rr < ROWS) & (cc >= 0) & (cc < COLS) & t[0];
        end
        return ok;
    endfunction

    // A cell belongs to a colour only when the other colour's bit is clear
    assign m_r   = snap_r_q & ~snap_b_q;
    assign m_b   = snap_b_q & ~snap_r_q;
    assign last  = (row_q == LAST_R) && (col_q == LAST_C);
    assign load  = (state_q == S_IDLE && start) || (state_q == S_DONE && (pend_q || start));
    assign full  = &(snap_r_q | snap_b_q);
    assign bad_n = |(snap_r_q & snap_b_q);
    assign fr_n  = fr_q | (|hit_r);
    assign fb_n  = fb_q | (|hit_b);

    // Direction checks for the current anchor: 0 +col, 1 +row, 2 +row+col, 3 +row-col
    always_comb begin
        for (int d = 0; d < 4; d++) begin
            hit_r[d] = run_at(m_r, int'(row_q), int'(col_q), (d == 0) ? 0 : 1, (d == 1) ? 0 : (d == 3) ? -1 : 1);
            hit_b[d] = run_at(m_b, int'(row_q), int'(col_q), (d == 0) ? 0 : 1, (d == 1) ? 0 : (d == 3) ? -1 : 1);
        end
    end

    // State register
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next state: clear_game aborts everything, a pending or fresh start re-enters SCAN straight from DONE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  state_d = start ? S_SCAN : S_IDLE;
            S_SCAN:  state_d = last ? S_DONE : S_SCAN;
            S_DONE:  state_d = (pend_q || start) ? S_SCAN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (clear_game) state_d = S_IDLE;
    end

    // FSM outputs
    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
    end

    // Snapshot, anchor walk, per-scan findings and sticky verdicts (verdicts settle as DONE is entered)
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            snap_r_q    <= '0;
            snap_b_q    <= '0;
            row_q       <= '0;
            col_q       <= '0;
            pend_q      <= 1'b0;
            fr_q        <= 1'b0;
            fb_q        <= 1'b0;
            red_win_q   <= 1'b0;
            black_win_q <= 1'b0;
            draw_q      <= 1'b0;
            bad_q       <= 1'b0;
        end else if (clear_game) begin
            pend_q      <= 1'b0;
            red_win_q   <= 1'b0;
            black_win_q <= 1'b0;
            draw_q      <= 1'b0;
            bad_q       <= 1'b0;
        end else begin
            pend_q <= load ? 1'b0 : pend_q | (busy & start);
            if (load) begin
                snap_r_q <= board_red;
                snap_b_q <= board_black;
                row_q    <= '0;
                col_q    <= '0;
                fr_q     <= 1'b0;
                fb_q     <= 1'b0;
            end else if (state_q == S_SCAN) begin
                col_q <= (col_q == LAST_C) ? 3'd0 : col_q + 3'd1;
                row_q <= (col_q == LAST_C) ? row_q + 3'd1 : row_q;
                fr_q  <= fr_n;
                fb_q  <= fb_n;
            end
            if (state_q == S_SCAN && last) begin
                red_win_q   <= red_win_q | fr_n;
                black_win_q <= black_win_q | fb_n;
                draw_q      <= draw_q | (full & ~fr_n & ~fb_n & ~red_win_q & ~black_win_q);
                bad_q       <= bad_q | bad_n;
            end
        end
    end

    assign red_win   = red_win_q;
    assign black_win = black_win_q;
    assign draw      = draw_q;
    assign bad_cell  = bad_q;

`ifdef WIN_LOCATION_EN
    logic [3:0] hit;
    logic [1:0] hit_dir, loc_d_q, win_dir_q, ld_n;
    logic [2:0] loc_r_q, loc_c_q, win_row_q, win_col_q, lr_n, lc_n;
    logic       loc_v_q;

    assign hit     = hit_r | hit_b;
    assign hit_dir = hit[0] ? 2'd0 : hit[1] ? 2'd1 : hit[2] ? 2'd2 : 2'd3;
    assign lr_n    = loc_v_q ? loc_r_q : row_q;
    assign lc_n    = loc_v_q ? loc_c_q : col_q;
    assign ld_n    = loc_v_q ? loc_d_q : hit_dir;

    // First hit of this scan in scan order; published only if no earlier win is on record
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            loc_v_q   <= 1'b0;
            loc_r_q   <= '0;
            loc_c_q   <= '0;
            loc_d_q   <= '0;
            win_row_q <= '0;
            win_col_q <= '0;
            win_dir_q <= '0;
        end else if (clear_game) begin
            loc_v_q   <= 1'b0;
            win_row_q <= '0;
            win_col_q <= '0;
            win_dir_q <= '0;
        end else begin
            if (load) begin
                loc_v_q <= 1'b0;
            end else if (state_q == S_SCAN && !loc_v_q && |hit) begin
                loc_v_q <= 1'b1;
                loc_r_q <= row_q;
                loc_c_q <= col_q;
                loc_d_q <= hit_dir;
            end
            if (state_q == S_SCAN && last && !(red_win_q || black_win_q) && (fr_n || fb_n)) begin
                win_row_q <= lr_n;
                win_col_q <= lc_n;
                win_dir_q <= ld_n;
            end
        end
    end

    assign win_row = win_row_q;
    assign win_col = win_col_q;
    assign win_dir = win_dir_q;
`else
    assign win_row = '0;
    assign win_col = '0;
    assign win_dir = '0;
`endif
endmodule

// File: tb/tb_board_win_scanner.sv
// tb_board_win_scanner: table-driven board verdicts plus start/pending, clear and reset sequences
module tb_board_win_scanner;
    localparam int N = 42;

`ifdef WIN_LOCATION_EN
    localparam bit LOC = 1'b1;
`else
    localparam bit LOC = 1'b0;
`endif

    logic         frame_clk = 1'b0, Reset = 1'b1, start = 1'b0, clear_game = 1'b0;
    logic [N-1:0] board_red = '0, board_black = '0;
    logic         busy, done, red_win, black_win, draw, bad_cell;
    logic [2:0]   win_row, win_col;
    logic [1:0]   win_dir;

    board_win_scanner dut (
        .frame_clk(frame_clk), .Reset(Reset), .start(start), .clear_game(clear_game),
        .board_red(board_red), .board_black(board_black), .busy(busy), .done(done),
        .red_win(red_win), .black_win(black_win), .draw(draw), .bad_cell(bad_cell),
        .win_row(win_row), .win_col(win_col), .win_dir(win_dir)
    );

    always #5 frame_clk = ~frame_clk;

    int edge_cnt = 0;
    always @(posedge frame_clk) edge_cnt++;

    typedef struct {
        logic [N-1:0] red, black;
        logic         rw, bw, dr, bad;
        logic [2:0]   r, c;
        logic [1:0]   d;
    } vec_t;

    typedef struct {
        logic       rw, bw, dr, bad;
        logic [2:0] r, c;
        logic [1:0] d;
        int         at;
    } exp_t;

    exp_t sb[$];
    int   asserts = 0, fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge frame_clk) begin
        exp_t e;
        if (!Reset && done) begin
            if (sb.size() == 0) begin
                asserts++;
                fails++;
                $display("FAIL unexpected_done: got done=1 expected no done (edge %0d)", edge_cnt);
            end else begin
                e = sb.pop_front();
                chk("done_cycle", edge_cnt, e.at);
                chk("red_win", red_win, e.rw);
                chk("black_win", black_win, e.bw);
                chk("draw", draw, e.dr);
                chk("bad_cell", bad_cell, e.bad);
                chk("win_row", win_row, LOC ? e.r : 3'd0);
                chk("win_col", win_col, LOC ? e.c : 3'd0);
                chk("win_dir", win_dir, LOC ? e.d : 2'd0);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge frame_clk);
    endtask

    task automatic press();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic do_clear();
        clear_game = 1'b1;
        tick(1);
        clear_game = 1'b0;
    endtask

    task automatic kick(input exp_t e);
        e.at = edge_cnt + 43;
        sb.push_back(e);
        press();
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() > 0 && n < 200) begin
            tick(1);
            n++;
        end
        if (sb.size() > 0) begin
            asserts++;
            fails++;
            $display("FAIL done_timeout: got no done within 200 cycles, expected %0d pending verdicts", sb.size());
            sb.delete();
        end
        tick(1);
    endtask

    function automatic logic [N-1:0] b4(input int a, input int b, input int c, input int d);
        logic [N-1:0] v = '0;
        v[a] = 1'b1;
        v[b] = 1'b1;
        v[c] = 1'b1;
        v[d] = 1'b1;
        return v;
    endfunction

    function automatic logic [N-1:0] pat_red();
        logic [N-1:0] v = '0;
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 7; c++)
                v[r*7+c] = (((c >> 1) + r) % 2) == 0;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input string nm);
        exp_t e;
        do_clear();
        board_red   = v.red;
        board_black = v.black;
        e.rw = v.rw; e.bw = v.bw; e.dr = v.dr; e.bad = v.bad;
        e.r = v.r; e.c = v.c; e.d = v.d; e.at = 0;
        kick(e);
        chk({nm, "_busy_scan"}, busy, 1'b1);
        wait_idle();
        chk({nm, "_busy_idle"}, busy, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    vec_t         vt[12];
    logic [N-1:0] fr, fb;
    exp_t         e;

    initial begin
        fr = pat_red();
        fb = ~fr;
        vt[0]  = '{'0, '0, 0, 0, 0, 0, 0, 0, 0};
        vt[1]  = '{b4(0, 1, 2, 3), '0, 1, 0, 0, 0, 0, 0, 0};
        vt[2]  = '{b4(3, 4, 5, 7), b4(6, 13, 20, 27), 0, 1, 0, 0, 0, 6, 1};
        vt[3]  = '{b4(3, 9, 15, 21), '0, 1, 0, 0, 0, 0, 3, 3};
        vt[4]  = '{fr, fb, 0, 0, 1, 0, 0, 0, 0};
        vt[5]  = '{fr | 42'h7F, fb & ~42'h7F, 1, 0, 0, 0, 0, 0, 0};
        vt[6]  = '{b4(0, 1, 2, 3), b4(0, 0, 0, 0), 0, 0, 0, 1, 0, 0, 0};
        vt[7]  = '{b4(0, 1, 2, 3), b4(7, 8, 9, 10), 1, 1, 0, 0, 0, 0, 0};
        vt[8]  = '{b4(38, 39, 40, 41), '0, 1, 0, 0, 0, 5, 3, 0};
        vt[9]  = '{'0, b4(17, 25, 33, 41), 0, 1, 0, 0, 2, 3, 2};
        vt[10] = '{b4(5, 6, 7, 8), '0, 0, 0, 0, 0, 0, 0, 0};
        vt[11] = '{fr, fb | b4(41, 41, 41, 41), 0, 0, 1, 1, 0, 0, 0};

        tick(2);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_flags", {red_win, black_win, draw, bad_cell}, 4'b0);
        chk("reset_loc", {win_row, win_col, win_dir}, 8'b0);
        Reset = 1'b0;
        tick(2);

        for (int i = 0; i < 12; i++) run_vec(vt[i], $sformatf("vec%0d", i));

        // Board changed mid-scan and a second start while busy: first verdict from the original snapshot,
        // second scan chains from DONE, extra starts merge, location stays on the earlier win
        do_clear();
        board_red   = b4(0, 1, 2, 3);
        board_black = '0;
        e = '{1, 0, 0, 0, 0, 0, 0, 0};
        kick(e);
        tick(9);
        board_red   = '0;
        board_black = b4(6, 13, 20, 27);
        tick(10);
        e = sb[0];
        e.bw = 1'b1;
        e.at = e.at + 43;
        sb.push_back(e);
        press();
        tick(4);
        press();
        wait_idle();
        chk("pend_busy_idle", busy, 1'b0);

        // clear_game mid-scan after wins are on record: abort, no done, pending dropped
        chk("pre_clear_red", red_win, 1'b1);
        press();
        tick(5);
        press();
        tick(8);
        do_clear();
        chk("clear_busy", busy, 1'b0);
        chk("clear_flags", {red_win, black_win, draw, bad_cell}, 4'b0);
        chk("clear_loc", {win_row, win_col, win_dir}, 8'b0);
        tick(60);
        chk("clear_stays_idle", busy, 1'b0);

        // Async reset mid-scan with a win recorded
        board_red   = b4(0, 1, 2, 3);
        board_black = '0;
        e = '{1, 0, 0, 0, 0, 0, 0, 0};
        kick(e);
        wait_idle();
        press();
        tick(20);
        #2 Reset = 1'b1;
        #1;
        chk("areset_busy", busy, 1'b0);
        chk("areset_red", red_win, 1'b0);
        tick(2);
        Reset = 1'b0;
        tick(50);
        chk("areset_idle", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule
